// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I core, its instruction ROM and the ROM loader.
package rv32i_pkg;

    // Word-address width of the instruction ROM (1024 words = 4 KB image).
    localparam int ROM_ADDR_LENGTH = 10;

    // Loader sequencing: wait for start, stream bytes, write the tail word, report.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } rom_loader_state_t;

endpackage

// File: rtl/rom_loader.sv
// Byte-stream to 32-bit word packer driving the instruction ROM write port.
// Handshake: a byte transfers on a rising clk edge where s_valid and s_ready
// are both 1; s_ready depends only on the loader state, never on s_valid.
// Bytes fill lanes 0..3 little-endian; a full word (or the s_last tail,
// zero-padded) is written one cycle after its final byte is accepted.
// word_count counts words written and is updated together with the we pulse.
module rom_loader
    import rv32i_pkg::*;
#(
    parameter int ADDR_LENGTH = ROM_ADDR_LENGTH,
    parameter int MEM_SIZE    = 2 ** ADDR_LENGTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   s_valid,
    input  logic [7:0]             s_data,
    input  logic                   s_last,
    output logic                   s_ready,
    output logic                   we,
    output logic [ADDR_LENGTH-1:0] waddr,
    output logic [31:0]            wdata,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow,
    output logic [ADDR_LENGTH:0]   word_count
);

    localparam logic [ADDR_LENGTH:0] MEM_WORDS = (ADDR_LENGTH + 1)'(MEM_SIZE);

    rom_loader_state_t      state_q, state_d;
    logic [1:0]             lane_q, lane_d;
    logic [31:0]            buf_q, buf_d;
    logic [ADDR_LENGTH-1:0] addr_q, addr_d;
    logic [ADDR_LENGTH:0]   count_q, count_d;
    logic                   done_q, done_d;
    logic                   ovf_q, ovf_d;
    logic                   we_q, we_d;
    logic [ADDR_LENGTH-1:0] waddr_q, waddr_d;
    logic [31:0]            wdata_q, wdata_d;

    logic                   full;
    logic [31:0]            pack_word;

    // Next-state logic: FSM sequencing, byte packing and write-port staging.
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        buf_d   = buf_q;
        addr_d  = addr_q;
        count_d = count_q;
        done_d  = done_q;
        ovf_d   = ovf_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;

        // Once the ROM is full every further byte is dropped.
        full = (count_q == MEM_WORDS);

        // Lane 0 starts a fresh word so unfilled upper lanes read as zero.
        pack_word = (lane_q == 2'd0) ? 32'd0 : buf_q;
        pack_word[{lane_q, 3'b000} +: 8] = s_data;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = LOAD;
                    lane_d  = 2'd0;
                    buf_d   = 32'd0;
                    addr_d  = '0;
                    count_d = '0;
                    done_d  = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            LOAD: begin
                if (s_valid) begin
                    lane_d = lane_q + 2'd1;
                    if (full) begin
                        ovf_d = 1'b1;
                    end else begin
                        buf_d = pack_word;
                        if (lane_q == 2'd3 || s_last) begin
                            we_d    = 1'b1;
                            waddr_d = addr_q;
                            wdata_d = pack_word;
                            addr_d  = addr_q + ADDR_LENGTH'(1);
                            count_d = count_q + (ADDR_LENGTH + 1)'(1);
                        end
                    end
                    if (s_last) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                // The tail word's we pulse is on the outputs during this cycle.
                state_d = DONE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lane_q  <= 2'd0;
            buf_q   <= 32'd0;
            addr_q  <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            buf_q   <= buf_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    // Output mapping; everything except the state decodes is a register.
    always_comb begin
        s_ready    = (state_q == LOAD);
        busy       = (state_q == LOAD) || (state_q == FLUSH);
        we         = we_q;
        waddr      = waddr_q;
        wdata      = wdata_q;
        done       = done_q;
        overflow   = ovf_q;
        word_count = count_q;
    end

endmodule

// File: tb/tb_rom_loader.sv
// Bench for rom_loader: a default-size instance (1024 words) and a 4-word
// instance share one byte stream, each with its own expected-write queue.
module tb_rom_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'd0;
    logic        s_last = 1'b0;

    logic        b_s_ready, b_we, b_busy, b_done, b_overflow;
    logic [9:0]  b_waddr;
    logic [31:0] b_wdata;
    logic [10:0] b_word_count;

    logic        m_s_ready, m_we, m_busy, m_done, m_overflow;
    logic [1:0]  m_waddr;
    logic [31:0] m_wdata;
    logic [2:0]  m_word_count;

    int          checks = 0;
    int          failures = 0;
    int          accepted = 0;

    logic [7:0]  img_q[$];
    logic [63:0] exp_q[$];
    logic [63:0] exp_s_q[$];
    int          exp_wc, exp_s_wc;
    logic        exp_ov, exp_s_ov;
    logic [63:0] b_got, b_exp, m_got, m_exp;

    rom_loader dut (
        .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_last(s_last), .s_ready(b_s_ready), .we(b_we), .waddr(b_waddr),
        .wdata(b_wdata), .busy(b_busy), .done(b_done), .overflow(b_overflow),
        .word_count(b_word_count)
    );

    rom_loader #(.ADDR_LENGTH(2)) dut_small (
        .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_last(s_last), .s_ready(m_s_ready), .we(m_we), .waddr(m_waddr),
        .wdata(m_wdata), .busy(m_busy), .done(m_done), .overflow(m_overflow),
        .word_count(m_word_count)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached before summary");
        $fatal(1, "watchdog");
    end

    // Scoreboard: every write strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (b_we === 1'b1) begin
            checks++;
            b_got = {32'(b_waddr), b_wdata};
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL big_write_unexpected got addr=%0d data=%h required no write", b_waddr, b_wdata);
            end else begin
                b_exp = exp_q.pop_front();
                if (b_got !== b_exp) begin
                    failures++;
                    $display("FAIL big_write got addr=%0d data=%h required addr=%0d data=%h",
                             b_got[63:32], b_got[31:0], b_exp[63:32], b_exp[31:0]);
                end
            end
        end
        if (m_we === 1'b1) begin
            checks++;
            m_got = {32'(m_waddr), m_wdata};
            if (exp_s_q.size() == 0) begin
                failures++;
                $display("FAIL small_write_unexpected got addr=%0d data=%h required no write", m_waddr, m_wdata);
            end else begin
                m_exp = exp_s_q.pop_front();
                if (m_got !== m_exp) begin
                    failures++;
                    $display("FAIL small_write got addr=%0d data=%h required addr=%0d data=%h",
                             m_got[63:32], m_got[31:0], m_exp[63:32], m_exp[31:0]);
                end
            end
        end
    end

    // Reference model: the image packed little-endian into ceil(n/4) words,
    // of which only the first MEM_SIZE are written; overflow iff n > 4*MEM_SIZE.
    task automatic model_load();
        int n;
        int words;
        logic [31:0] w;
        n = img_q.size();
        words = (n + 3) / 4;
        for (int i = 0; i < words; i++) begin
            w = 32'd0;
            for (int k = 0; k < 4; k++) begin
                if (4 * i + k < n) w = w | (32'(img_q[4 * i + k]) << (8 * k));
            end
            if (i < 1024) exp_q.push_back({32'(i), w});
            if (i < 4) exp_s_q.push_back({32'(i), w});
        end
        exp_wc   = (words < 1024) ? words : 1024;
        exp_s_wc = (words < 4) ? words : 4;
        exp_ov   = (n > 4096);
        exp_s_ov = (n > 16);
    endtask

    task automatic random_image(input int len);
        img_q.delete();
        for (int i = 0; i < len; i++) img_q.push_back(8'($urandom_range(0, 255)));
    endtask

    // Driver: one-cycle start pulse; returns on the negedge after the edge.
    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Driver: streams img_q[lo..hi]; gap_mode 0 continuous, 1 toggling, 2 random.
    // Returns on the negedge following the last accepting edge.
    task automatic send_image(input int lo, input int hi, input bit last_en, input int gap_mode);
        int waited;
        for (int i = lo; i <= hi; i++) begin
            if (gap_mode == 1 && i > lo) begin
                s_valid = 1'b0;
                @(negedge clk);
            end
            if (gap_mode == 2) begin
                repeat ($urandom_range(0, 2)) begin
                    s_valid = 1'b0;
                    @(negedge clk);
                end
            end
            s_valid = 1'b1;
            s_data  = img_q[i];
            s_last  = last_en && (i == hi);
            waited  = 0;
            while ((b_s_ready !== 1'b1 || m_s_ready !== 1'b1) && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            if (b_s_ready !== 1'b1 || m_s_ready !== 1'b1) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout byte=%0d s_ready=%b/%b required 1/1", i, b_s_ready, m_s_ready);
                break;
            end
            @(posedge clk);
            accepted++;
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({b_s_ready, b_we, b_busy, b_done, b_overflow, b_waddr, b_wdata, b_word_count} !== '0) begin
            failures++;
            $display("FAIL reset_big got rdy=%b we=%b busy=%b done=%b ovf=%b addr=%0d data=%h wc=%0d required all 0",
                     b_s_ready, b_we, b_busy, b_done, b_overflow, b_waddr, b_wdata, b_word_count);
        end
        checks++;
        if ({m_s_ready, m_we, m_busy, m_done, m_overflow, m_waddr, m_wdata, m_word_count} !== '0) begin
            failures++;
            $display("FAIL reset_small got rdy=%b we=%b busy=%b done=%b ovf=%b addr=%0d data=%h wc=%0d required all 0",
                     m_s_ready, m_we, m_busy, m_done, m_overflow, m_waddr, m_wdata, m_word_count);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        img_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        model_load();
        do_start();
        checks++;
        if (b_busy !== 1'b1 || b_s_ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_busy_after_start got busy=%b rdy=%b required 1/1", b_busy, b_s_ready);
        end
        send_image(0, 7, 1'b1, 0);
        checks++;
        if (b_we !== 1'b1 || b_done !== 1'b0 || b_busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_flush_cycle got we=%b done=%b busy=%b required 1/0/1", b_we, b_done, b_busy);
        end
        @(negedge clk);
        checks++;
        if (b_done !== 1'b1 || b_busy !== 1'b0 || b_we !== 1'b0) begin
            failures++;
            $display("FAIL basic_done_latency got done=%b busy=%b we=%b required 1/0/0", b_done, b_busy, b_we);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (int'(b_word_count) !== exp_wc || b_overflow !== exp_ov || exp_q.size() != 0) begin
            failures++;
            $display("FAIL basic_big_end got wc=%0d ovf=%b pending=%0d required wc=%0d ovf=%b pending=0",
                     b_word_count, b_overflow, exp_q.size(), exp_wc, exp_ov);
        end
        checks++;
        if (int'(m_word_count) !== exp_s_wc || m_done !== 1'b1 || exp_s_q.size() != 0) begin
            failures++;
            $display("FAIL basic_small_end got wc=%0d done=%b pending=%0d required wc=%0d done=1 pending=0",
                     m_word_count, m_done, exp_s_q.size(), exp_s_wc);
        end
    endtask

    task automatic test_partial();
        img_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
        model_load();
        do_start();
        send_image(0, 5, 1'b1, 0);
        checks++;
        if (b_we !== 1'b1 || b_waddr !== 10'd1 || b_wdata !== 32'h00001615) begin
            failures++;
            $display("FAIL partial_tail got we=%b addr=%0d data=%h required we=1 addr=1 data=00001615",
                     b_we, b_waddr, b_wdata);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (int'(b_word_count) !== 2 || b_done !== 1'b1 || b_overflow !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL partial_end got wc=%0d done=%b ovf=%b pending=%0d required wc=2 done=1 ovf=0 pending=0",
                     b_word_count, b_done, b_overflow, exp_q.size());
        end
    endtask

    task automatic test_toggle();
        img_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        model_load();
        do_start();
        send_image(0, 3, 1'b1, 1);
        checks++;
        if (b_we !== 1'b1 || b_waddr !== 10'd0 || b_wdata !== 32'hDDCCBBAA) begin
            failures++;
            $display("FAIL toggle_write got we=%b addr=%0d data=%h required we=1 addr=0 data=ddccbbaa",
                     b_we, b_waddr, b_wdata);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (int'(b_word_count) !== 1 || b_done !== 1'b1 || exp_q.size() != 0 || exp_s_q.size() != 0) begin
            failures++;
            $display("FAIL toggle_end got wc=%0d done=%b pending=%0d/%0d required wc=1 done=1 pending=0/0",
                     b_word_count, b_done, exp_q.size(), exp_s_q.size());
        end
    endtask

    task automatic test_overflow();
        random_image(20);
        model_load();
        do_start();
        accepted = 0;
        send_image(0, 19, 1'b1, 0);
        checks++;
        if (m_we !== 1'b0 || accepted != 20) begin
            failures++;
            $display("FAIL overflow_drain got we=%b accepted=%0d required we=0 accepted=20", m_we, accepted);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (int'(m_word_count) !== 4 || m_overflow !== 1'b1 || m_done !== 1'b1 || exp_s_q.size() != 0) begin
            failures++;
            $display("FAIL overflow_small_end got wc=%0d ovf=%b done=%b pending=%0d required wc=4 ovf=1 done=1 pending=0",
                     m_word_count, m_overflow, m_done, exp_s_q.size());
        end
        checks++;
        if (int'(b_word_count) !== 5 || b_overflow !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL overflow_big_end got wc=%0d ovf=%b pending=%0d required wc=5 ovf=0 pending=0",
                     b_word_count, b_overflow, exp_q.size());
        end
    endtask

    task automatic test_start_in_done();
        checks++;
        if (m_done !== 1'b1 || m_overflow !== 1'b1) begin
            failures++;
            $display("FAIL restart_precondition got done=%b ovf=%b required 1/1", m_done, m_overflow);
        end
        do_start();
        checks++;
        if (m_done !== 1'b0 || m_overflow !== 1'b0 || m_word_count !== 3'd0 || m_busy !== 1'b1 || b_done !== 1'b0) begin
            failures++;
            $display("FAIL restart_clear got done=%b ovf=%b wc=%0d busy=%b big_done=%b required 0/0/0/1/0",
                     m_done, m_overflow, m_word_count, m_busy, b_done);
        end
        random_image(7);
        model_load();
        send_image(0, 6, 1'b1, 0);
        repeat (3) @(negedge clk);
        checks++;
        if (int'(m_word_count) !== 2 || m_overflow !== 1'b0 || exp_q.size() != 0 || exp_s_q.size() != 0) begin
            failures++;
            $display("FAIL restart_end got wc=%0d ovf=%b pending=%0d/%0d required wc=2 ovf=0 pending=0/0",
                     m_word_count, m_overflow, exp_q.size(), exp_s_q.size());
        end
    endtask

    task automatic test_start_in_load();
        random_image(11);
        model_load();
        do_start();
        send_image(0, 4, 1'b0, 0);
        do_start();
        checks++;
        if (b_busy !== 1'b1 || int'(b_word_count) !== 1) begin
            failures++;
            $display("FAIL load_start_ignored got busy=%b wc=%0d required busy=1 wc=1", b_busy, b_word_count);
        end
        send_image(5, 10, 1'b1, 0);
        repeat (3) @(negedge clk);
        checks++;
        if (int'(b_word_count) !== exp_wc || b_done !== 1'b1 || exp_q.size() != 0 || exp_s_q.size() != 0) begin
            failures++;
            $display("FAIL load_start_end got wc=%0d done=%b pending=%0d/%0d required wc=%0d done=1 pending=0/0",
                     b_word_count, b_done, exp_q.size(), exp_s_q.size(), exp_wc);
        end
    endtask

    task automatic test_reset_mid_load();
        logic [31:0] w0;
        random_image(5);
        w0 = {img_q[3], img_q[2], img_q[1], img_q[0]};
        exp_q.push_back({32'd0, w0});
        exp_s_q.push_back({32'd0, w0});
        do_start();
        send_image(0, 4, 1'b0, 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({b_s_ready, b_we, b_busy, b_done, b_overflow, b_waddr, b_wdata, b_word_count} !== '0 ||
            {m_s_ready, m_we, m_busy, m_done, m_overflow, m_waddr, m_wdata, m_word_count} !== '0) begin
            failures++;
            $display("FAIL midload_reset got rdy=%b we=%b busy=%b wc=%0d data=%h required all 0",
                     b_s_ready, b_we, b_busy, b_word_count, b_wdata);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || exp_s_q.size() != 0 || b_s_ready !== 1'b0) begin
            failures++;
            $display("FAIL midload_after got pending=%0d/%0d rdy=%b required 0/0/0",
                     exp_q.size(), exp_s_q.size(), b_s_ready);
        end
        random_image(4);
        model_load();
        do_start();
        send_image(0, 3, 1'b1, 0);
        repeat (3) @(negedge clk);
        checks++;
        if (int'(b_word_count) !== 1 || b_done !== 1'b1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL midload_reload got wc=%0d done=%b pending=%0d required wc=1 done=1 pending=0",
                     b_word_count, b_done, exp_q.size());
        end
    endtask

    task automatic test_random();
        int len;
        for (int it = 0; it < 8; it++) begin
            len = $urandom_range(1, 30);
            random_image(len);
            model_load();
            do_start();
            send_image(0, len - 1, 1'b1, 2);
            repeat (3) @(negedge clk);
            checks++;
            if (int'(b_word_count) !== exp_wc || b_overflow !== exp_ov || b_done !== 1'b1 || exp_q.size() != 0) begin
                failures++;
                $display("FAIL random_big it=%0d len=%0d got wc=%0d ovf=%b done=%b pending=%0d required wc=%0d ovf=%b done=1 pending=0",
                         it, len, b_word_count, b_overflow, b_done, exp_q.size(), exp_wc, exp_ov);
            end
            checks++;
            if (int'(m_word_count) !== exp_s_wc || m_overflow !== exp_s_ov || m_done !== 1'b1 || exp_s_q.size() != 0) begin
                failures++;
                $display("FAIL random_small it=%0d len=%0d got wc=%0d ovf=%b done=%b pending=%0d required wc=%0d ovf=%b done=1 pending=0",
                         it, len, m_word_count, m_overflow, m_done, exp_s_q.size(), exp_s_wc, exp_s_ov);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_partial();
        test_toggle();
        test_overflow();
        test_start_in_done();
        test_start_in_load();
        test_reset_mid_load();
        test_random();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
